// File: rtl/uart_pkg.sv
// Shared constants and types for the configurable UART transmitter.
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam int OS_DEFAULT = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  // Mode 2'b11 is deliberately treated like PAR_NONE.
  function automatic logic par_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tx_cfg_if.sv
// Bus-side write/config/status bundle of the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DBIT  = 8,
  parameter int DIV_W = 11
);
  logic             wr_en;
  logic [DBIT-1:0]  wr_data;
  logic [DIV_W-1:0] divisor;
  logic [1:0]       parity_mode;
  logic             stop2;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             busy;
  logic             tx_done_tick;
  logic             tx;

  modport master (
    output wr_en, wr_data, divisor, parity_mode, stop2,
    input  full, empty, overflow, busy, tx_done_tick, tx
  );
  modport slave (
    input  wr_en, wr_data, divisor, parity_mode, stop2,
    output full, empty, overflow, busy, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; a push is still taken when
// full if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count;
  logic              push, pop;

  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overflow <= wr_en && !push;
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Queued UART transmitter: baud tick generator, TX FIFO and serialiser with
// per-frame latched divisor, parity mode and stop-bit count.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int OS     = OS_DEFAULT,
  parameter int DIV_W  = 11,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  uart_tx_cfg_if.slave bus
);
  localparam int SW = $clog2(2*OS);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  tx_state_e        state;
  logic [DIV_W-1:0] div_q, tcnt;
  logic [1:0]       par_q;
  logic             stop_q, par_bit;
  logic [DBIT-1:0]  shreg, fifo_data;
  logic [SW-1:0]    scnt;
  logic [NW-1:0]    ncnt;
  logic             tick, pop, fifo_empty, bit_end, stop_end;

  uart_sync_fifo #(.WIDTH(DBIT), .ADDR_W(ADDR_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (bus.full),
    .empty    (fifo_empty),
    .overflow (bus.overflow)
  );

  assign bus.empty = fifo_empty;
  assign bus.busy  = (state != IDLE);
  assign pop       = (state == IDLE) && !fifo_empty;
  assign tick      = (tcnt == div_q);
  assign bit_end   = tick && (scnt == SW'(OS-1));
  assign stop_end  = tick && (scnt == (stop_q ? SW'(2*OS-1) : SW'(OS-1)));

  // tx is registered from the current state, so the line lags the FSM by one
  // clk; this gives the N+2 start-bit latency and the single idle clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bus.tx           <= 1'b1;
      bus.tx_done_tick <= 1'b0;
      tcnt             <= '0;
      scnt             <= '0;
      ncnt             <= '0;
      shreg            <= '0;
      div_q            <= '0;
      par_q            <= PAR_NONE;
      stop_q           <= 1'b0;
      par_bit          <= 1'b0;
    end else begin
      bus.tx_done_tick <= 1'b0;
      tcnt <= (state == IDLE || tick) ? '0 : tcnt + 1'b1;
      case (state)
        IDLE: begin
          bus.tx <= 1'b1;
          if (pop) begin
            shreg   <= fifo_data;
            div_q   <= bus.divisor;
            par_q   <= bus.parity_mode;
            stop_q  <= bus.stop2;
            par_bit <= (^fifo_data) ^ (bus.parity_mode == PAR_ODD);
            scnt    <= '0;
            ncnt    <= '0;
            state   <= START;
          end
        end
        START: begin
          bus.tx <= 1'b0;
          if (bit_end) begin
            scnt  <= '0;
            state <= DATA;
          end else if (tick) scnt <= scnt + 1'b1;
        end
        DATA: begin
          bus.tx <= shreg[0];
          if (bit_end) begin
            scnt  <= '0;
            shreg <= shreg >> 1;
            if (ncnt == NW'(DBIT-1)) state <= par_en(par_q) ? PARITY : STOP;
            else                     ncnt  <= ncnt + 1'b1;
          end else if (tick) scnt <= scnt + 1'b1;
        end
        PARITY: begin
          bus.tx <= par_bit;
          if (bit_end) begin
            scnt  <= '0;
            state <= STOP;
          end else if (tick) scnt <= scnt + 1'b1;
        end
        STOP: begin
          bus.tx <= 1'b1;
          if (stop_end) begin
            scnt             <= '0;
            bus.tx_done_tick <= 1'b1;
            state            <= IDLE;
          end else if (tick) scnt <= scnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter combining a baud-tick generator, a transmit FIFO and a serialiser in one block. It supports runtime parity (none/even/odd), 1 or 2 stop bits and a programmable baud divisor. Sits between the bus-side write interface and the tx pin, replacing the separate BGEN/buffer/uart_tx chain with a single queued transmitter.

Parameters:
DBIT, 8, data bits per frame (5..9), sent LSB first
OS, 16, baud ticks per bit (oversample factor)
DIV_W, 11, width of divisor input
ADDR_W, 3, FIFO address width; depth = 2**ADDR_W

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  push wr_data into FIFO
wr_data  in  DBIT  word to transmit
divisor  in  DIV_W  tick period = divisor+1 clk cycles
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2  in  1  1 = two stop bits, 0 = one
full  out  1  FIFO full
empty  out  1  FIFO empty
overflow  out  1  1-cycle pulse: wr_en while full (word dropped)
busy  out  1  high from frame start through last stop bit
tx_done_tick  out  1  1-cycle pulse at end of final stop bit
tx  out  1  serial line, registered, idle high

Behaviour:
- Reset (sync, clk edge with reset=1): FIFO pointers/count cleared, state IDLE, tx=1, busy=0, tx_done_tick=0, overflow=0, full=0, empty=1, tick counter=0. Reset mid-frame aborts the frame; tx=1 on that edge.
- FIFO: synchronous, registered count. Write accepted when wr_en && !full. Pop only when !empty. Write and pop in the same cycle while full: both happen, count unchanged. Write into empty FIFO: empty falls the next cycle; no same-cycle pop. Pointers wrap modulo depth.
- Tick generator: counter 0..div_q; tick asserted for one clk when count==div_q, then restarts at 0. div_q=0 gives a tick every clk. Counter cleared on leaving IDLE, so a bit lasts exactly (div_q+1)*OS clks.
- Config latch: divisor, parity_mode and stop2 are captured into div_q/par_q/stop_q on the pop cycle; changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  IDLE: tx=1. If !empty: pop, load shift register, latch config, clear tick and bit counters, go to START.
  START: tx=0 for OS ticks, then DATA.
  DATA: tx=shift[0]; after OS ticks shift right; after DBIT bits go to PARITY if par_q is even/odd, otherwise STOP.
  PARITY: tx = XOR of data bits (even), inverted (odd); OS ticks, then STOP.
  STOP: tx=1 for OS ticks (2*OS if stop_q); at the last tick pulse tx_done_tick and return to IDLE.
- Latency: wr_en at edge N into an idle, empty FIFO; pop at N+1; tx falls at N+2. Back-to-back frames insert exactly one idle clk (tx=1) between stop end and the next start bit.
- busy = (state != IDLE).
- Frame length in clks: (div_q+1)*OS*(1+DBIT+P+S), where P is 0/1 and S is 1/2.

Decomposition:
- Package uart_pkg: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), FSM state enum, default OS.
- Sub-module uart_sync_fifo (parametrised by width and ADDR_W) providing full, empty and count; baud counter and FSM stay in uart_tx_cfg.

Test Plan:
- DBIT=8, OS=16, divisor=3, parity none, stop2=0; write 0xA5. tx sampled mid-bit every 64 clks must read 0,1,0,1,0,0,1,0,1,1. Frame is 640 clks; tx_done_tick fires once; busy spans exactly 640 clks.
- Same word with even parity: parity bit = 0. With odd parity: parity bit = 1. Frame is 704 clks. With stop2=1 and parity none: stop high for 128 clks, total 704 clks.
- Write 9 words back-to-back with depth 8 while the FSM is idle. The first pops at N+1, so there is no overflow. Then fill until full=1; an extra write gives an overflow pulse and the word is dropped. All accepted words are transmitted in order, each separated by one idle clk.
- divisor=0: bit = 16 clks. Change divisor to 7 mid-frame: the current frame keeps 16-clk bits, and the next frame uses 128-clk bits.
- Assert reset during DATA bit 4: tx=1, busy=0 and empty=1 on the next clk. No tx_done_tick is produced. A new write then transmits normally.
- Write while full and pop in the same cycle: the write is accepted, there is no overflow, and full stays 1.
